atm_multi_account_ctrl: RTL and testbench

//  Next-generation ATM session controller: one FSM serving NUM_ACCOUNTS accounts.

---
 rtl/atm_multi_account_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_atm_multi_account_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_multi_account_ctrl.sv
// ATM session controller: one FSM serving NUM_ACCOUNTS accounts with per-account balance/PIN.
// Latency: cardIn to PIN state 2 cycles, opValid to result pulse 2 cycles; pulses last 1 cycle.
// Optional PIN lockout enabled by defining ATM_PIN_LOCKOUT_EN; otherwise Card_Retained is tied 0.
module atm_multi_account_ctrl #(
  parameter int NUM_ACCOUNTS = 4,
  parameter int ACC_W        = 2,
  parameter int PIN_W        = 4,
  parameter int BAL_W        = 16,
  parameter int INIT_BAL     = 500,
  parameter logic [PIN_W-1:0] DEFAULT_PIN = 4'b1010,
  parameter int MAX_TRIES    = 3,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cardIn,
  input  logic [ACC_W-1:0] accountId,
  input  logic             Language,
  input  logic [PIN_W-1:0] password,
  input  logic             pinValid,
  input  logic [1:0]       opCode,
  input  logic             opValid,
  input  logic [BAL_W-1:0] inputAmount,
  input  logic             Another_Operation,
  input  logic             ejectCard,
  output logic             correctPassword,
  output logic             langOut,
  output logic [BAL_W-1:0] balance,
  output logic             Balance_Shown,
  output logic             Deposited_Successfully,
  output logic             Withdrawed_Successfully,
  output logic             Pin_Changed,
  output logic             Op_Error,
  output logic             Card_Retained,
  output logic             ATM_Usage_Finished
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LANG, S_PIN, S_MENU, S_EXEC, S_DONE, S_EJECT
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [1:0]       op_q;
  logic [BAL_W-1:0] amt_q;
  logic [BAL_W-1:0] bal_q   [NUM_ACCOUNTS];
  logic [PIN_W-1:0] pin_q   [NUM_ACCOUNTS];
  logic [TRY_W-1:0] tries_q [NUM_ACCOUNTS];
  logic [TMR_W-1:0] timer_q;
  logic [BAL_W-1:0] balance_q;
  logic corr_q, lang_q, shown_q, dep_q, wd_q, pinchg_q, err_q, fin_q;
`ifdef ATM_PIN_LOCKOUT_EN
  logic [NUM_ACCOUNTS-1:0] lock_q;
  logic                    retain_q;
`endif

  logic             abort_d, timeout_d, pin_ok_d, wd_bad_d;
  logic [BAL_W-1:0] cur_bal_d;
  logic [BAL_W:0]   dep_sum_d;

  // Decode helpers for the current account and session conditions.
  always_comb begin
    cur_bal_d = bal_q[acc_q];
    abort_d   = ejectCard | ~cardIn;
    timeout_d = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    pin_ok_d  = (password == pin_q[acc_q]);
    dep_sum_d = {1'b0, cur_bal_d} + {1'b0, amt_q};
    wd_bad_d  = (amt_q == '0) || (amt_q > cur_bal_d);
  end

  // Session FSM with registered outputs and per-account state; timer clears unless explicitly counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      op_q      <= '0;
      amt_q     <= '0;
      timer_q   <= '0;
      balance_q <= '0;
      corr_q    <= 1'b0;
      lang_q    <= 1'b0;
      shown_q   <= 1'b0;
      dep_q     <= 1'b0;
      wd_q      <= 1'b0;
      pinchg_q  <= 1'b0;
      err_q     <= 1'b0;
      fin_q     <= 1'b0;
      for (int k = 0; k < NUM_ACCOUNTS; k++) begin
        bal_q[k]   <= BAL_W'(INIT_BAL);
        pin_q[k]   <= DEFAULT_PIN + PIN_W'(k);
        tries_q[k] <= '0;
      end
`ifdef ATM_PIN_LOCKOUT_EN
      lock_q   <= '0;
      retain_q <= 1'b0;
`endif
    end else begin
      shown_q  <= 1'b0;
      dep_q    <= 1'b0;
      wd_q     <= 1'b0;
      pinchg_q <= 1'b0;
      err_q    <= 1'b0;
      fin_q    <= 1'b0;
      timer_q  <= '0;
`ifdef ATM_PIN_LOCKOUT_EN
      retain_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (cardIn) begin
            acc_q   <= accountId;
            state_q <= S_LANG;
          end
        end
        S_LANG: begin
          lang_q <= Language;
          if (abort_d) begin
            state_q <= S_EJECT;
`ifdef ATM_PIN_LOCKOUT_EN
          end else if (lock_q[acc_q]) begin
            retain_q <= 1'b1;
            state_q  <= S_EJECT;
`endif
          end else begin
            state_q <= S_PIN;
          end
        end
        S_PIN: begin
          if (abort_d) begin
            state_q <= S_EJECT;
          end else if (pinValid) begin
            if (pin_ok_d) begin
              corr_q         <= 1'b1;
              tries_q[acc_q] <= '0;
              state_q        <= S_MENU;
`ifdef ATM_PIN_LOCKOUT_EN
            end else if (tries_q[acc_q] == TRY_W'(MAX_TRIES - 1)) begin
              lock_q[acc_q]  <= 1'b1;
              retain_q       <= 1'b1;
              tries_q[acc_q] <= '0;
              state_q        <= S_EJECT;
`endif
            end else if (tries_q[acc_q] != TRY_W'(MAX_TRIES)) begin
              tries_q[acc_q] <= tries_q[acc_q] + TRY_W'(1);
            end
          end else if (timeout_d) begin
            state_q <= S_EJECT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_MENU: begin
          // ejectCard outranks a simultaneous opValid: the op is dropped.
          if (abort_d) begin
            state_q <= S_EJECT;
          end else if (opValid) begin
            op_q    <= opCode;
            amt_q   <= inputAmount;
            state_q <= S_EXEC;
          end else if (timeout_d) begin
            state_q <= S_EJECT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_EXEC: begin
          state_q <= S_DONE;
          case (op_q)
            2'b00: begin
              pin_q[acc_q] <= amt_q[PIN_W-1:0];
              pinchg_q     <= 1'b1;
            end
            2'b01: begin
              balance_q <= cur_bal_d;
              shown_q   <= 1'b1;
            end
            2'b10: begin
              if (dep_sum_d[BAL_W]) begin
                err_q <= 1'b1;
              end else begin
                bal_q[acc_q] <= dep_sum_d[BAL_W-1:0];
                balance_q    <= dep_sum_d[BAL_W-1:0];
                dep_q        <= 1'b1;
              end
            end
            default: begin
              if (wd_bad_d) begin
                err_q <= 1'b1;
              end else begin
                bal_q[acc_q] <= cur_bal_d - amt_q;
                balance_q    <= cur_bal_d - amt_q;
                wd_q         <= 1'b1;
              end
            end
          endcase
        end
        S_DONE: begin
          state_q <= (abort_d || !Another_Operation) ? S_EJECT : S_MENU;
        end
        S_EJECT: begin
          fin_q   <= 1'b1;
          corr_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign correctPassword         = corr_q;
  assign langOut                 = lang_q;
  assign balance                 = balance_q;
  assign Balance_Shown           = shown_q;
  assign Deposited_Successfully  = dep_q;
  assign Withdrawed_Successfully = wd_q;
  assign Pin_Changed             = pinchg_q;
  assign Op_Error                = err_q;
  assign ATM_Usage_Finished      = fin_q;
`ifdef ATM_PIN_LOCKOUT_EN
  assign Card_Retained = retain_q;
`else
  assign Card_Retained = 1'b0;
`endif

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Testbench for atm_multi_account_ctrl: cycle-by-cycle vector table plus
// hand-written sequences for lockout, asynchronous reset and menu timeout.
module tb_atm_multi_account_ctrl;

  logic        clk;
  logic        reset;
  logic        cardIn;
  logic [1:0]  accountId;
  logic        Language;
  logic [3:0]  password;
  logic        pinValid;
  logic [1:0]  opCode;
  logic        opValid;
  logic [15:0] inputAmount;
  logic        Another_Operation;
  logic        ejectCard;
  logic        correctPassword;
  logic        langOut;
  logic [15:0] balance;
  logic        Balance_Shown;
  logic        Deposited_Successfully;
  logic        Withdrawed_Successfully;
  logic        Pin_Changed;
  logic        Op_Error;
  logic        Card_Retained;
  logic        ATM_Usage_Finished;

  atm_multi_account_ctrl dut (
    .clk                     (clk),
    .reset                   (reset),
    .cardIn                  (cardIn),
    .accountId               (accountId),
    .Language                (Language),
    .password                (password),
    .pinValid                (pinValid),
    .opCode                  (opCode),
    .opValid                 (opValid),
    .inputAmount             (inputAmount),
    .Another_Operation       (Another_Operation),
    .ejectCard               (ejectCard),
    .correctPassword         (correctPassword),
    .langOut                 (langOut),
    .balance                 (balance),
    .Balance_Shown           (Balance_Shown),
    .Deposited_Successfully  (Deposited_Successfully),
    .Withdrawed_Successfully (Withdrawed_Successfully),
    .Pin_Changed             (Pin_Changed),
    .Op_Error                (Op_Error),
    .Card_Retained           (Card_Retained),
    .ATM_Usage_Finished      (ATM_Usage_Finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse vector order: shown, deposited, withdrawn, pin changed, error, retained, finished
  localparam logic [6:0] NP = 7'b0000000;
  localparam logic [6:0] SH = 7'b1000000;
  localparam logic [6:0] DP = 7'b0100000;
  localparam logic [6:0] WD = 7'b0010000;
  localparam logic [6:0] PC = 7'b0001000;
  localparam logic [6:0] ER = 7'b0000100;
  localparam logic [6:0] FN = 7'b0000001;

  typedef struct {
    logic        card;
    logic [1:0]  acc;
    logic        lang;
    logic [3:0]  pw;
    logic        pv;
    logic [1:0]  op;
    logic        ov;
    logic [15:0] amt;
    logic        ano;
    logic        ej;
    logic        ecorr;
    logic        elang;
    logic [6:0]  epul;
    logic [15:0] ebal;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] pul;
  assign pul = {Balance_Shown, Deposited_Successfully, Withdrawed_Successfully,
                Pin_Changed, Op_Error, Card_Retained, ATM_Usage_Finished};

  function automatic vec_t mk(input logic c, input logic [1:0] a, input logic l,
                              input logic [3:0] pw, input logic pv, input logic [1:0] op,
                              input logic ov, input logic [15:0] amt, input logic ano,
                              input logic ej, input logic ec, input logic el,
                              input logic [6:0] ep, input logic [15:0] eb);
    vec_t r;
    r.card = c;  r.acc = a;  r.lang = l;  r.pw = pw;  r.pv = pv;  r.op = op;
    r.ov = ov;   r.amt = amt; r.ano = ano; r.ej = ej;
    r.ecorr = ec; r.elang = el; r.epul = ep; r.ebal = eb;
    return r;
  endfunction

  function automatic vec_t inp(input logic c, input logic [1:0] a, input logic l,
                               input logic [3:0] pw, input logic pv, input logic [1:0] op,
                               input logic ov, input logic [15:0] amt, input logic ano,
                               input logic ej);
    return mk(c, a, l, pw, pv, op, ov, amt, ano, ej, 1'b0, 1'b0, NP, 16'd0);
  endfunction

  task automatic drive(input vec_t r);
    cardIn = r.card;  accountId = r.acc;  Language = r.lang;
    password = r.pw;  pinValid = r.pv;    opCode = r.op;
    opValid = r.ov;   inputAmount = r.amt;
    Another_Operation = r.ano;  ejectCard = r.ej;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  int  n;
  logic seen;

  initial begin
    // Session A: acc0 PIN 1010, withdraw 64 then show balance.
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 0,0,NP,16'd0));
    tbl.push_back(mk(1,0,1,4'd0,0,0,0,16'd0,0,0, 0,1,NP,16'd0));
    tbl.push_back(mk(1,0,0,4'b1010,1,0,0,16'd0,0,0, 1,1,NP,16'd0));
    tbl.push_back(mk(1,0,0,4'd0,0,3,1,16'd64,0,0, 1,1,NP,16'd0));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 1,1,WD,16'd436));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,1,0, 1,1,NP,16'd436));
    tbl.push_back(mk(1,0,0,4'd0,0,1,1,16'd0,0,0, 1,1,NP,16'd436));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 1,1,SH,16'd436));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 1,1,NP,16'd436));
    tbl.push_back(mk(0,0,0,4'd0,0,0,0,16'd0,0,0, 0,1,FN,16'd436));
    // Session B: acc3 PIN 1101, one wrong PIN, withdraw 600/0 rejected, show, withdraw all.
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,0,0, 0,1,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,0,0, 0,0,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'b1010,1,0,0,16'd0,0,0, 0,0,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'b1101,1,0,0,16'd0,0,0, 1,0,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,3,1,16'd600,0,0, 1,0,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,0,0, 1,0,ER,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,1,0, 1,0,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,3,1,16'd0,0,0, 1,0,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,0,0, 1,0,ER,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,1,0, 1,0,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,1,1,16'd0,0,0, 1,0,NP,16'd436));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,0,0, 1,0,SH,16'd500));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,1,0, 1,0,NP,16'd500));
    tbl.push_back(mk(1,3,0,4'd0,0,3,1,16'd500,0,0, 1,0,NP,16'd500));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,0,0, 1,0,WD,16'd0));
    tbl.push_back(mk(1,3,0,4'd0,0,0,0,16'd0,0,0, 1,0,NP,16'd0));
    tbl.push_back(mk(0,3,0,4'd0,0,0,0,16'd0,0,0, 0,0,FN,16'd0));
    // Session C: acc1 PIN 1011, deposit overflow, deposits up to 65535, overflow by 1, eject beats op.
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,0,0, 0,0,NP,16'd0));
    tbl.push_back(mk(1,1,1,4'd0,0,0,0,16'd0,0,0, 0,1,NP,16'd0));
    tbl.push_back(mk(1,1,0,4'b1011,1,0,0,16'd0,0,0, 1,1,NP,16'd0));
    tbl.push_back(mk(1,1,0,4'd0,0,2,1,16'd65100,0,0, 1,1,NP,16'd0));
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,0,0, 1,1,ER,16'd0));
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,1,0, 1,1,NP,16'd0));
    tbl.push_back(mk(1,1,0,4'd0,0,2,1,16'd100,0,0, 1,1,NP,16'd0));
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,0,0, 1,1,DP,16'd600));
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,1,0, 1,1,NP,16'd600));
    tbl.push_back(mk(1,1,0,4'd0,0,2,1,16'd64935,0,0, 1,1,NP,16'd600));
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,0,0, 1,1,DP,16'd65535));
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,1,0, 1,1,NP,16'd65535));
    tbl.push_back(mk(1,1,0,4'd0,0,2,1,16'd1,0,0, 1,1,NP,16'd65535));
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,0,0, 1,1,ER,16'd65535));
    tbl.push_back(mk(1,1,0,4'd0,0,0,0,16'd0,1,0, 1,1,NP,16'd65535));
    tbl.push_back(mk(1,1,0,4'd0,0,1,1,16'd0,0,1, 1,1,NP,16'd65535));
    tbl.push_back(mk(0,1,0,4'd0,0,0,0,16'd0,0,0, 0,1,FN,16'd65535));
    tbl.push_back(mk(0,1,0,4'd0,0,0,0,16'd0,0,0, 0,1,NP,16'd65535));
    // Session D: acc0 changes PIN to 0101, then old PIN rejected and new one accepted.
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 0,1,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 0,0,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'b1010,1,0,0,16'd0,0,0, 1,0,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'd0,0,0,1,16'h0005,0,0, 1,0,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 1,0,PC,16'd65535));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 1,0,NP,16'd65535));
    tbl.push_back(mk(0,0,0,4'd0,0,0,0,16'd0,0,0, 0,0,FN,16'd65535));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 0,0,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 0,0,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'b1010,1,0,0,16'd0,0,0, 0,0,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'b0101,1,0,0,16'd0,0,0, 1,0,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'd0,0,1,1,16'd0,0,0, 1,0,NP,16'd65535));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 1,0,SH,16'd436));
    tbl.push_back(mk(1,0,0,4'd0,0,0,0,16'd0,0,0, 1,0,NP,16'd436));
    tbl.push_back(mk(0,0,0,4'd0,0,0,0,16'd0,0,0, 0,0,FN,16'd436));
    // Session E: acc2, card pulled while waiting for PIN.
    tbl.push_back(mk(1,2,0,4'd0,0,0,0,16'd0,0,0, 0,0,NP,16'd436));
    tbl.push_back(mk(1,2,1,4'd0,0,0,0,16'd0,0,0, 0,1,NP,16'd436));
    tbl.push_back(mk(0,2,0,4'd0,0,0,0,16'd0,0,0, 0,1,NP,16'd436));
    tbl.push_back(mk(0,2,0,4'd0,0,0,0,16'd0,0,0, 0,1,FN,16'd436));

    reset = 1'b0;
    drive(inp(0,0,0,4'd0,0,0,0,16'd0,0,0));
    repeat (3) tick();
    chk("reset corr", correctPassword, 0);
    chk("reset lang", langOut, 0);
    chk("reset pulses", pul, NP);
    chk("reset balance", balance, 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      chk($sformatf("row%0d corr", i), correctPassword, tbl[i].ecorr);
      chk($sformatf("row%0d lang", i), langOut, tbl[i].elang);
      chk($sformatf("row%0d pulses", i), pul, tbl[i].epul);
      chk($sformatf("row%0d balance", i), balance, tbl[i].ebal);
    end

    // Three wrong PINs on acc2 (PIN 1100).
    drive(inp(1,2,0,4'd0,0,0,0,16'd0,0,0)); tick();
    drive(inp(1,2,0,4'd0,0,0,0,16'd0,0,0)); tick();
    for (int t = 0; t < 3; t++) begin
      drive(inp(1,2,0,4'b0000,1,0,0,16'd0,0,0)); tick();
`ifdef ATM_PIN_LOCKOUT_EN
      chk($sformatf("lock try%0d retained", t), Card_Retained, (t == 2));
`else
      chk($sformatf("lock try%0d retained", t), Card_Retained, 0);
`endif
      chk($sformatf("lock try%0d corr", t), correctPassword, 0);
      chk($sformatf("lock try%0d finished", t), ATM_Usage_Finished, 0);
    end
`ifdef ATM_PIN_LOCKOUT_EN
    drive(inp(1,2,0,4'd0,0,0,0,16'd0,0,0)); tick();
    chk("lock finished", ATM_Usage_Finished, 1);
    drive(inp(0,2,0,4'd0,0,0,0,16'd0,0,0)); tick();
    drive(inp(1,2,0,4'd0,0,0,0,16'd0,0,0)); tick();
    chk("relock retained early", Card_Retained, 0);
    drive(inp(1,2,0,4'b1100,1,0,0,16'd0,0,0)); tick();
    chk("relock retained", Card_Retained, 1);
    chk("relock corr", correctPassword, 0);
    drive(inp(0,2,0,4'd0,0,0,0,16'd0,0,0)); tick();
    chk("relock finished", ATM_Usage_Finished, 1);
    tick();
`else
    drive(inp(1,2,0,4'b0000,1,0,0,16'd0,0,0)); tick();
    chk("nolock 4th try finished", ATM_Usage_Finished, 0);
    drive(inp(1,2,0,4'b1100,1,0,0,16'd0,0,0)); tick();
    chk("nolock accept corr", correctPassword, 1);
    drive(inp(1,2,0,4'd0,0,0,0,16'd0,0,1)); tick();
    drive(inp(0,2,0,4'd0,0,0,0,16'd0,0,0)); tick();
    chk("nolock finished", ATM_Usage_Finished, 1);
    tick();
`endif

    // Reset while in MENU of acc0 (PIN currently 0101, last balance 436).
    drive(inp(1,0,0,4'd0,0,0,0,16'd0,0,0)); tick();
    drive(inp(1,0,1,4'd0,0,0,0,16'd0,0,0)); tick();
    drive(inp(1,0,0,4'b0101,1,0,0,16'd0,0,0)); tick();
    chk("pre-reset corr", correctPassword, 1);
    chk("pre-reset lang", langOut, 1);
    drive(inp(1,0,0,4'd0,0,0,0,16'd0,0,0));
    #2 reset = 1'b0;
    #1;
    chk("async reset corr", correctPassword, 0);
    chk("async reset lang", langOut, 0);
    chk("async reset balance", balance, 0);
    chk("async reset pulses", pul, NP);
    tick();
    reset = 1'b1;
    tick(); tick();
    drive(inp(1,0,0,4'b1010,1,0,0,16'd0,0,0)); tick();
    chk("post-reset default pin", correctPassword, 1);
    drive(inp(1,0,0,4'd0,0,1,1,16'd0,0,0)); tick();
    drive(inp(1,0,0,4'd0,0,0,0,16'd0,0,0)); tick();
    chk("post-reset shown", Balance_Shown, 1);
    chk("post-reset balance", balance, 500);
    drive(inp(1,0,0,4'd0,0,0,0,16'd0,1,0)); tick();

    // Idle in MENU until the inactivity timeout ends the session.
    drive(inp(1,0,0,4'd0,0,0,0,16'd0,0,0));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      tick();
      n++;
      if (ATM_Usage_Finished) seen = 1'b1;
    end
    chk("timeout cycles to finish", n, 256);
    chk("timeout corr", correctPassword, 0);
    drive(inp(0,0,0,4'd0,0,0,0,16'd0,0,0)); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
